add_sub_acc: RTL and testbench

Downstream accumulation stage for the signed adder/subtractor. It accepts the SIZE+1-bit signed result over a valid/ready handshake and sums BLOCK_LEN consecutive results into a wider signed accumulator. It presents each block total, with a per-block overflow flag, to the next stage over a second valid/ready handshake. It is the registered boundary between the combinational arithmetic datapath and its consumers.

---
 rtl/add_sub_acc.sv | 133 +++++++++++++
 tb/tb_add_sub_acc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_acc.sv
// add_sub_acc: sums BLOCK_LEN signed results from the adder/subtractor into a
// wider signed accumulator. Each block total is handed downstream over a
// valid/ready handshake, together with a sticky per-block overflow flag.
// Optional feature macro: ADD_SUB_ACC_SAT_EN. When it is defined, an overflow
// clamps the accumulator to its most positive or most negative value.
// When it is undefined, the accumulator wraps in two's complement.
module add_sub_acc #(
  parameter int SIZE      = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4,
  localparam int CW       = $clog2(BLOCK_LEN + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic signed [SIZE:0]    res_i,
  output logic                    ready_o,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    acc_valid_o,
  input  logic                    ready_i,
  output logic                    ovf_o,
  output logic [CW-1:0]           count_o
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

`ifdef ADD_SUB_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ovf_q, ovf_d;

  logic signed [ACC_W-1:0]  res_ext;
  logic signed [ACC_W-1:0]  sum_raw;
  logic signed [ACC_W-1:0]  sum_sel;
  logic                     ovf_now;
  logic                     xfer;
  logic                     last_beat;

  // Sign-extend the incoming result, add it, and flag signed overflow
  always_comb begin
    res_ext = ACC_W'(res_i);
    sum_raw = acc_q + res_ext;
    ovf_now = (acc_q[ACC_W-1] == res_ext[ACC_W-1]) &&
              (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef ADD_SUB_ACC_SAT_EN
    if (ovf_now) begin
      sum_sel = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sel = sum_raw;
    end
`else
    sum_sel = sum_raw;
`endif
  end

  // An accepted sample needs ACC state and no clear in the same cycle
  always_comb begin
    xfer      = valid_i && (state_q == ST_ACC) && !clear_i;
    last_beat = (count_q == CW'(BLOCK_LEN - 1));
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear wins, then the final beat or downstream accept
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC:  if (xfer && last_beat) state_d = ST_OUT;
        ST_OUT:  if (ready_i)           state_d = ST_ACC;
        default:                        state_d = ST_ACC;
      endcase
    end
  end

  // Handshake outputs are decoded straight from the state register
  always_comb begin
    ready_o     = (state_q == ST_ACC);
    acc_valid_o = (state_q == ST_OUT);
  end

  // Datapath next values: accumulate on transfer, zero on clear or handoff
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i || ((state_q == ST_OUT) && ready_i)) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (xfer) begin
      acc_d   = sum_sel;
      count_d = count_q + CW'(1);
      ovf_d   = ovf_q | ovf_now;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_o   = acc_q;
  assign ovf_o   = ovf_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_add_sub_acc.sv
// Testbench for add_sub_acc: a vector table on the default build, plus short
// hand-written sequences for reset, overflow (ACC_W=10) and BLOCK_LEN=1.
module tb_add_sub_acc;

  logic clk;
  logic rst_n;

  // Instance 0: default parameters
  logic               clear0, valid0, ready0;
  logic signed [8:0]  res0;
  logic               rdy_o0, av0, ovf0;
  logic signed [15:0] acc0;
  logic [2:0]         cnt0;

  // Instance 1: ACC_W=10 for overflow
  logic               clear1, valid1, ready1;
  logic signed [8:0]  res1;
  logic               rdy_o1, av1, ovf1;
  logic signed [9:0]  acc1;
  logic [2:0]         cnt1;

  // Instance 2: BLOCK_LEN=1
  logic               clear2, valid2, ready2;
  logic signed [8:0]  res2;
  logic               rdy_o2, av2, ovf2;
  logic signed [15:0] acc2;
  logic [0:0]         cnt2;

  int checks = 0;
  int errors = 0;

  add_sub_acc u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear0), .valid_i(valid0),
    .res_i(res0), .ready_o(rdy_o0), .acc_o(acc0), .acc_valid_o(av0),
    .ready_i(ready0), .ovf_o(ovf0), .count_o(cnt0)
  );

  add_sub_acc #(.SIZE(8), .ACC_W(10), .BLOCK_LEN(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1), .valid_i(valid1),
    .res_i(res1), .ready_o(rdy_o1), .acc_o(acc1), .acc_valid_o(av1),
    .ready_i(ready1), .ovf_o(ovf1), .count_o(cnt1)
  );

  add_sub_acc #(.SIZE(8), .ACC_W(16), .BLOCK_LEN(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear2), .valid_i(valid2),
    .res_i(res2), .ready_o(rdy_o2), .acc_o(acc2), .acc_valid_o(av2),
    .ready_i(ready2), .ovf_o(ovf2), .count_o(cnt2)
  );

  typedef struct {
    logic valid;
    int   res;
    logic clear;
    logic ready;
    logic exp_rdy;
    logic exp_av;
    int   exp_acc;
    logic exp_ovf;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic v, int r, logic c, logic rd, logic er,
                              logic ea, int eacc, logic eo, int ec);
    vec_t t;
    t.valid = v;  t.res = r;  t.clear = c;  t.ready = rd;
    t.exp_rdy = er;  t.exp_av = ea;  t.exp_acc = eacc;
    t.exp_ovf = eo;  t.exp_cnt = ec;
    return t;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one vector on instance 0, clock it, then compare all outputs
  task automatic applyStimulus(input vec_t v, input int idx);
    valid0 = v.valid;
    res0   = 9'(v.res);
    clear0 = v.clear;
    ready0 = v.ready;
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d.ready_o", idx), int'(rdy_o0), int'(v.exp_rdy));
    checkOutput($sformatf("v%0d.acc_valid", idx), int'(av0), int'(v.exp_av));
    checkOutput($sformatf("v%0d.acc", idx), int'(acc0), v.exp_acc);
    checkOutput($sformatf("v%0d.ovf", idx), int'(ovf0), int'(v.exp_ovf));
    checkOutput($sformatf("v%0d.count", idx), int'(cnt0), v.exp_cnt);
  endtask

  initial begin
    int exp_mid;
    int exp_fin;

    rst_n  = 1'b0;
    clear0 = 0; valid0 = 0; ready0 = 0; res0 = '0;
    clear1 = 0; valid1 = 0; ready1 = 0; res1 = '0;
    clear2 = 0; valid2 = 0; ready2 = 0; res2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Mid-block reset: accept two samples, then drop rst_n between edges
    valid0 = 1; res0 = 9'sd20; ready0 = 1;
    repeat (2) @(posedge clk);
    #1 valid0 = 0;
    checkOutput("pre_reset.count", int'(cnt0), 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset.ready_o", int'(rdy_o0), 1);
    checkOutput("reset.acc_valid", int'(av0), 0);
    checkOutput("reset.acc", int'(acc0), 0);
    checkOutput("reset.ovf", int'(ovf0), 0);
    checkOutput("reset.count", int'(cnt0), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Block sum with ready_i high
    vecs.push_back(mk(1,   10, 0, 1, 1, 0,   10, 0, 1));
    vecs.push_back(mk(1,   -3, 0, 1, 1, 0,    7, 0, 2));
    vecs.push_back(mk(1,  100, 0, 1, 1, 0,  107, 0, 3));
    vecs.push_back(mk(1, -256, 0, 1, 0, 1, -149, 0, 4));
    vecs.push_back(mk(0,    0, 0, 1, 1, 0,    0, 0, 0));
    // Same block under backpressure; valid pulses in OUT are ignored
    vecs.push_back(mk(1,   10, 0, 0, 1, 0,   10, 0, 1));
    vecs.push_back(mk(1,   -3, 0, 0, 1, 0,    7, 0, 2));
    vecs.push_back(mk(1,  100, 0, 0, 1, 0,  107, 0, 3));
    vecs.push_back(mk(1, -256, 0, 0, 0, 1, -149, 0, 4));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(i[0], 77, 0, 0, 0, 1, -149, 0, 4));
    vecs.push_back(mk(0,    0, 0, 1, 1, 0,    0, 0, 0));
    // Clear mid-block drops the coincident sample
    vecs.push_back(mk(1,    7, 0, 1, 1, 0,    7, 0, 1));
    vecs.push_back(mk(0,   99, 0, 1, 1, 0,    7, 0, 1));
    vecs.push_back(mk(1,    8, 0, 1, 1, 0,   15, 0, 2));
    vecs.push_back(mk(1,   50, 1, 1, 1, 0,    0, 0, 0));
    vecs.push_back(mk(1,    1, 0, 1, 1, 0,    1, 0, 1));
    vecs.push_back(mk(1,    2, 0, 1, 1, 0,    3, 0, 2));
    vecs.push_back(mk(1,    3, 0, 1, 1, 0,    6, 0, 3));
    vecs.push_back(mk(1,    4, 0, 1, 0, 1,   10, 0, 4));
    vecs.push_back(mk(0,    0, 0, 1, 1, 0,    0, 0, 0));
    // Clear while presenting a total
    vecs.push_back(mk(1,    1, 0, 0, 1, 0,    1, 0, 1));
    vecs.push_back(mk(1,    1, 0, 0, 1, 0,    2, 0, 2));
    vecs.push_back(mk(1,    1, 0, 0, 1, 0,    3, 0, 3));
    vecs.push_back(mk(1,    1, 0, 0, 0, 1,    4, 0, 4));
    vecs.push_back(mk(0,    0, 1, 0, 1, 0,    0, 0, 0));
    vecs.push_back(mk(0,    0, 0, 0, 1, 0,    0, 0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);
    valid0 = 0; clear0 = 0;

    // Overflow on ACC_W=10: four results of +255
`ifdef ADD_SUB_ACC_SAT_EN
    exp_mid = 511;
    exp_fin = 511;
`else
    exp_mid = -259;
    exp_fin = -4;
`endif
    valid1 = 1; res1 = 9'sd255; ready1 = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ovf.acc_after2", int'(acc1), 510);
    checkOutput("ovf.flag_after2", int'(ovf1), 0);
    @(posedge clk);
    #1;
    checkOutput("ovf.acc_after3", int'(acc1), exp_mid);
    checkOutput("ovf.flag_after3", int'(ovf1), 1);
    @(posedge clk);
    #1 valid1 = 0;
    checkOutput("ovf.acc_valid", int'(av1), 1);
    checkOutput("ovf.acc_final", int'(acc1), exp_fin);
    checkOutput("ovf.flag_final", int'(ovf1), 1);
    ready1 = 1;
    @(posedge clk);
    #1 ready1 = 0;
    checkOutput("ovf.flag_cleared", int'(ovf1), 0);
    checkOutput("ovf.ready_back", int'(rdy_o1), 1);

    // BLOCK_LEN=1 with ready_i toggling
    valid2 = 1; res2 = 9'sd5; ready2 = 0;
    @(posedge clk);
    #1;
    checkOutput("bl1.av_a", int'(av2), 1);
    checkOutput("bl1.acc_a", int'(acc2), 5);
    checkOutput("bl1.ovf_a", int'(ovf2), 0);
    checkOutput("bl1.rdy_a", int'(rdy_o2), 0);
    res2 = -9'sd5; ready2 = 1;
    @(posedge clk);
    #1;
    checkOutput("bl1.av_b", int'(av2), 0);
    checkOutput("bl1.acc_b", int'(acc2), 0);
    ready2 = 0;
    @(posedge clk);
    #1;
    checkOutput("bl1.av_c", int'(av2), 1);
    checkOutput("bl1.acc_c", int'(acc2), -5);
    checkOutput("bl1.ovf_c", int'(ovf2), 0);
    valid2 = 0; ready2 = 1;
    @(posedge clk);
    #1;
    checkOutput("bl1.av_d", int'(av2), 0);
    checkOutput("bl1.rdy_d", int'(rdy_o2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
